vote: RTL and testbench

- Registered triple-modular-redundancy (TMR) majority voter.
- Takes three redundant copies of a W-bit signal (A, B, C) and produces the bitwise 2-of-3 majority on res one cycle later.
- Flags which copy disagreed and keeps saturating per-copy disagreement counters for fault monitoring.
- Sits between triplicated logic and the downstream single-copy consumer.

---
 rtl/vote_pkg.sv | 5 +
 rtl/vote_sat_cnt.sv | 16 +
 rtl/vote.sv | 59 +++++
 tb/tb_vote.sv | 129 ++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// vote_pkg: default widths shared by the voter and its counters
package vote_pkg;
  localparam int VOTE_W_DEFAULT = 1;
  localparam int VOTE_CNT_W_DEFAULT = 8;
endpackage

// File: rtl/vote_sat_cnt.sv
// vote_sat_cnt: saturating up-counter with synchronous clear taking priority
module vote_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/vote.sv
// vote: registered TMR bitwise 2-of-3 voter with per-copy disagreement monitoring
module vote
  import vote_pkg::*;
#(
  parameter int W     = VOTE_W_DEFAULT,
  parameter int CNT_W = VOTE_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [W-1:0]     A,
  input  logic [W-1:0]     B,
  input  logic [W-1:0]     C,
  input  logic             clr_cnt,
  output logic [W-1:0]     res,
  output logic             out_valid,
  output logic             all_agree,
  output logic             dis_a,
  output logic             dis_b,
  output logic             dis_c,
  output logic             multi_err,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
);
  logic [W-1:0] maj;
  logic         da, db, dc;
  always_comb begin
    maj = (A & B) | (A & C) | (B & C);
    da  = |(A ^ maj);
    db  = |(B ^ maj);
    dc  = |(C ^ maj);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res       <= '0;
      out_valid <= 1'b0;
      all_agree <= 1'b0;
      dis_a     <= 1'b0;
      dis_b     <= 1'b0;
      dis_c     <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res       <= maj;
        all_agree <= (A == B) && (B == C);
        dis_a     <= da;
        dis_b     <= db;
        dis_c     <= dc;
        // two losers means different copies were outvoted in different bits
        multi_err <= (da & db) | (da & dc) | (db & dc);
      end
    end
  end
  vote_sat_cnt #(.CNT_W(CNT_W)) u_cnt_a (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(in_valid & da), .cnt(cnt_a));
  vote_sat_cnt #(.CNT_W(CNT_W)) u_cnt_b (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(in_valid & db), .cnt(cnt_b));
  vote_sat_cnt #(.CNT_W(CNT_W)) u_cnt_c (.clk(clk), .rst_n(rst_n), .clr(clr_cnt), .inc(in_valid & dc), .cnt(cnt_c));
endmodule

// File: tb/tb_vote.sv
// tb_vote: randomized voter bench against a per-bit vote-counting reference model
module tb_vote;
  localparam int W = 4;
  localparam int CNT_W = 2;
  localparam int SAT = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, clr_cnt = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0, res;
  logic out_valid, all_agree, dis_a, dis_b, dis_c, multi_err;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c;
  int checks = 0, failures = 0;
  logic [W-1:0] m_res;
  bit m_ov, m_agree, m_me;
  bit m_dis[3];
  int m_cnt[3];

  vote #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(a), .B(b), .C(c), .clr_cnt(clr_cnt),
    .res(res), .out_valid(out_valid), .all_agree(all_agree), .dis_a(dis_a), .dis_b(dis_b),
    .dis_c(dis_c), .multi_err(multi_err), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_res = '0; m_ov = 0; m_agree = 0; m_me = 0;
    for (int i = 0; i < 3; i++) begin m_dis[i] = 0; m_cnt[i] = 0; end
  endtask

  task automatic model(input logic [W-1:0] x, y, z, input bit v, input bit clr);
    logic [W-1:0] maj;
    logic [W-1:0] cp[3];
    int ndis;
    cp[0] = x; cp[1] = y; cp[2] = z;
    for (int i = 0; i < W; i++) maj[i] = (int'(x[i]) + int'(y[i]) + int'(z[i])) >= 2;
    m_ov = v;
    if (v) begin
      ndis = 0;
      for (int k = 0; k < 3; k++) begin
        m_dis[k] = 0;
        for (int i = 0; i < W; i++) if (cp[k][i] != maj[i]) m_dis[k] = 1;
        ndis += int'(m_dis[k]);
      end
      m_res = maj;
      m_agree = (x == y) && (y == z);
      m_me = ndis > 1;
    end
    for (int k = 0; k < 3; k++)
      if (clr) m_cnt[k] = 0;
      else if (v && m_dis[k] && m_cnt[k] < SAT) m_cnt[k]++;
  endtask

  task automatic check_all();
    chk("res", res, m_res);
    chk("out_valid", out_valid, m_ov);
    chk("all_agree", all_agree, m_agree);
    chk("dis_a", dis_a, m_dis[0]);
    chk("dis_b", dis_b, m_dis[1]);
    chk("dis_c", dis_c, m_dis[2]);
    chk("multi_err", multi_err, m_me);
    chk("cnt_a", cnt_a, m_cnt[0]);
    chk("cnt_b", cnt_b, m_cnt[1]);
    chk("cnt_c", cnt_c, m_cnt[2]);
  endtask

  task automatic drive(input logic [W-1:0] x, y, z, input bit v, input bit clr);
    a = x; b = y; c = z; in_valid = v; clr_cnt = clr;
    @(posedge clk);
    model(x, y, z, v, clr);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int sat_exp[5] = '{1, 2, 3, 3, 3};
    logic [W-1:0] base, fa, fb, fc;
    reset_model();
    a = W'($urandom); b = W'($urandom); c = W'($urandom); in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    drive(4'h1, 4'h0, 4'h0, 1, 0);
    chk("first_res", res, 0);
    chk("first_dis_a", dis_a, 1);
    chk("first_cnt_a", cnt_a, 1);
    for (int k = 0; k < 8; k++) begin
      drive({W{k[2]}}, {W{k[1]}}, {W{k[0]}}, 1, 0);
      chk("exh_agree", all_agree, (k == 0 || k == 7));
    end
    drive(4'b1010, 4'b1011, 4'b0010, 1, 0);
    chk("mb_res", res, 4'b1010);
    chk("mb_multi", multi_err, 1);
    repeat (3) drive(W'($urandom), W'($urandom), W'($urandom), 0, 0);
    chk("gate_res", res, 4'b1010);
    drive(4'h0, 4'h0, 4'h0, 0, 1);
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, 4'h0, 4'h0, 1, 0);
      chk("sat_cnt_a", cnt_a, sat_exp[k]);
    end
    drive(4'hF, 4'h0, 4'h0, 1, 1);
    chk("clr_prio", cnt_a, 0);
    drive(4'h0, 4'h0, 4'h0, 0, 1);
    drive(4'h5, 4'h4, 4'h5, 1, 0);
    drive(4'h5, 4'h4, 4'h5, 1, 0);
    chk("pre_rst_cnt_b", cnt_b, 2);
    #2 rst_n = 1'b0;
    #1 reset_model();
    check_all();
    chk("async_res", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      base = W'($urandom);
      fa = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      fb = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      fc = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      drive(base ^ fa, base ^ fb, base ^ fc, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
